uart_rx_deserializer: RTL and testbench

//  Receive half of the UART: samples serial line sin at 16x baud and recovers start/data/parity/stop.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_sync.sv | 29 ++
 rtl/uart_rx_deserializer.sv | 175 +++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared types and constants for the UART receive path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_DATA     = 3'd2,
    ST_PARITY   = 3'd3,
    ST_STOP     = 3'd4,
    ST_BRK_WAIT = 3'd5
  } rx_state_t;

  localparam logic [1:0] WLEN_5 = 2'b00;
  localparam logic [1:0] WLEN_6 = 2'b01;
  localparam logic [1:0] WLEN_7 = 2'b10;
  localparam logic [1:0] WLEN_8 = 2'b11;

  localparam int RX_STAT_PE  = 0;
  localparam int RX_STAT_FE  = 1;
  localparam int RX_STAT_BRK = 2;

  typedef struct packed {
    logic [1:0] word_len;
    logic       par_en;
    logic       par_even;
    logic       par_stick;
  } rx_cfg_t;

  // Index of the final data bit for a given word-length code (5..8 bits).
  function automatic logic [2:0] last_bit_idx(input logic [1:0] wl);
    return {1'b0, wl} + 3'd4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_sync.sv
// ============================================================================
// Module  : uart_sync
// Brief   : Multi-stage synchronizer for an idle-high async input.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  // Reset to 1 so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[STAGES-2:0], d};
  end

  assign q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
// ============================================================================
// Module  : uart_rx_deserializer
// Brief   : UART receiver: oversampled start/data/parity/stop recovery with
//           single-cycle push of each character and its error status.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rx_deserializer
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       sin,
  input  logic [1:0] word_len,
  input  logic       par_en,
  input  logic       par_even,
  input  logic       par_stick,
  input  logic       fifo_full,
  output logic       rx_push,
  output logic [7:0] rx_data,
  output logic [2:0] rx_status,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int                 c_CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(OVERSAMPLE - 1);

  logic w_sin_s;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sin),
    .q   (w_sin_s)
  );

  rx_state_t          r_state,   w_state;
  logic [c_CNT_W-1:0] r_cnt,     w_cnt;
  logic [2:0]         r_bit_idx, w_bit_idx;
  logic [7:0]         r_shift,   w_shift;
  rx_cfg_t            r_cfg,     w_cfg;
  logic               r_par_bit, w_par_bit;
  logic               r_par_err, w_par_err;
  logic               r_rx_push, w_rx_push;
  logic               r_overrun, w_overrun;
  logic [7:0]         r_rx_data, w_rx_data;
  logic [2:0]         r_rx_status, w_rx_status;
  logic [2:0]         w_stat;
  logic               w_par_exp;
  logic               w_last;

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_bit_idx   = r_bit_idx;
    w_shift     = r_shift;
    w_cfg       = r_cfg;
    w_par_bit   = r_par_bit;
    w_par_err   = r_par_err;
    w_rx_push   = 1'b0;
    w_overrun   = 1'b0;
    w_rx_data   = r_rx_data;
    w_rx_status = r_rx_status;
    w_last      = (r_cnt == c_CNT_LAST);
    // Bits above the word length stay 0, so the full-byte XOR is the data parity.
    w_par_exp   = r_cfg.par_stick ? ~r_cfg.par_even : ((^r_shift) ^ ~r_cfg.par_even);
    w_stat                = '0;
    w_stat[RX_STAT_PE]    = r_par_err;
    w_stat[RX_STAT_FE]    = ~w_sin_s;
    w_stat[RX_STAT_BRK]   = ~w_sin_s && (r_shift == 8'h00) && (!r_cfg.par_en || !r_par_bit);

    if (baud_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_sin_s) begin
            w_state   = ST_START;
            w_cnt     = '0;
            w_shift   = '0;
            w_par_bit = 1'b0;
            w_par_err = 1'b0;
            w_cfg     = '{word_len: word_len, par_en: par_en,
                          par_even: par_even, par_stick: par_stick};
          end
        end
        ST_START: begin
          w_cnt = r_cnt + c_CNT_W'(1);
          if (r_cnt == c_CNT_HALF) begin
            w_cnt     = '0;
            w_bit_idx = '0;
            w_state   = w_sin_s ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          w_cnt = r_cnt + c_CNT_W'(1);
          if (w_last) begin
            w_shift[r_bit_idx] = w_sin_s;
            if (r_bit_idx == last_bit_idx(r_cfg.word_len))
              w_state = r_cfg.par_en ? ST_PARITY : ST_STOP;
            else
              w_bit_idx = r_bit_idx + 3'd1;
          end
        end
        ST_PARITY: begin
          w_cnt = r_cnt + c_CNT_W'(1);
          if (w_last) begin
            w_par_bit = w_sin_s;
            w_par_err = (w_sin_s != w_par_exp);
            w_state   = ST_STOP;
          end
        end
        ST_STOP: begin
          w_cnt = r_cnt + c_CNT_W'(1);
          if (w_last) begin
            if (fifo_full) begin
              w_overrun = 1'b1;
            end else begin
              w_rx_push   = 1'b1;
              w_rx_data   = r_shift;
              w_rx_status = w_stat;
            end
            w_state = w_sin_s ? ST_IDLE : ST_BRK_WAIT;
          end
        end
        ST_BRK_WAIT: begin
          if (w_sin_s) w_state = ST_IDLE;
        end
        default: w_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_cfg       <= '0;
      r_par_bit   <= 1'b0;
      r_par_err   <= 1'b0;
      r_rx_push   <= 1'b0;
      r_overrun   <= 1'b0;
      r_rx_data   <= '0;
      r_rx_status <= '0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_bit_idx   <= w_bit_idx;
      r_shift     <= w_shift;
      r_cfg       <= w_cfg;
      r_par_bit   <= w_par_bit;
      r_par_err   <= w_par_err;
      r_rx_push   <= w_rx_push;
      r_overrun   <= w_overrun;
      r_rx_data   <= w_rx_data;
      r_rx_status <= w_rx_status;
    end
  end

  assign rx_push   = r_rx_push;
  assign overrun   = r_overrun;
  assign rx_data   = r_rx_data;
  assign rx_status = r_rx_status;
  assign rx_busy   = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
// ============================================================================
// Module  : tb_uart_rx_deserializer
// Brief   : Randomized, scoreboarded bench for the UART receiver.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_deserializer;

  localparam int OS       = 16;
  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       sin = 1'b1;
  logic [1:0] word_len = 2'b11;
  logic       par_en = 1'b0;
  logic       par_even = 1'b0;
  logic       par_stick = 1'b0;
  logic       fifo_full = 1'b0;
  logic       rx_push;
  logic [7:0] rx_data;
  logic [2:0] rx_status;
  logic       overrun;
  logic       rx_busy;

  int vectors     = 0;
  int miscompares = 0;
  int div         = 0;

  typedef struct packed {
    logic       is_push;
    logic [7:0] data;
    logic [2:0] status;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  uart_rx_deserializer #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .sin       (sin),
    .word_len  (word_len),
    .par_en    (par_en),
    .par_even  (par_even),
    .par_stick (par_stick),
    .fifo_full (fifo_full),
    .rx_push   (rx_push),
    .rx_data   (rx_data),
    .rx_status (rx_status),
    .overrun   (overrun),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    div       = (div + 1) % TICK_DIV;
    baud_tick = (div == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: a character is what the line carried, judged by counting ones.
  function automatic exp_t model(input logic [1:0] wl, input bit pen, input bit peven,
                                 input bit pstick, input logic [7:0] data, input bit pbit,
                                 input bit stop, input bit full);
    exp_t m;
    int   n;
    int   ones;
    logic [7:0] d;
    bit   pe, fe, brk;
    n    = int'(wl) + 5;
    d    = data & 8'((1 << n) - 1);
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(d[i]);
    pe = 1'b0;
    if (pen) begin
      if (pstick) pe = (pbit != !peven);
      else        pe = (((ones + int'(pbit)) % 2) != (peven ? 0 : 1));
    end
    fe  = !stop;
    brk = fe && (d == 8'h00) && (!pen || !pbit);
    m.is_push = !full;
    m.data    = d;
    m.status  = {brk, fe, pe};
    return m;
  endfunction

  always @(negedge clk) begin
    if (!rst && (rx_push || overrun)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {30'b0, rx_push, overrun}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", {30'b0, rx_push, overrun}, mon_e.is_push ? 32'd2 : 32'd1);
        if (mon_e.is_push) begin
          check("rx_data", {24'b0, rx_data}, {24'b0, mon_e.data});
          check("rx_status", {29'b0, rx_status}, {29'b0, mon_e.status});
        end
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    sin = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [1:0] wl, input bit pen, input bit peven,
                            input bit pstick, input logic [7:0] data, input bit flip,
                            input bit stop1, input int nstop, input bit full);
    int n;
    int ones;
    bit pbit;
    n    = int'(wl) + 5;
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(data[i]);
    pbit = pstick ? !peven : (peven ? bit'(ones % 2) : !bit'(ones % 2));
    pbit = pbit ^ flip;
    word_len  = wl;
    par_en    = pen;
    par_even  = peven;
    par_stick = pstick;
    fifo_full = full;
    exp_q.push_back(model(wl, pen, peven, pstick, data, pbit, stop1, full));
    send_bit(1'b0);
    // Mid-frame config changes must not affect this character.
    word_len  = 2'($urandom);
    par_en    = 1'($urandom);
    par_even  = 1'($urandom);
    par_stick = 1'($urandom);
    for (int i = 0; i < n; i++) send_bit(data[i]);
    if (pen) send_bit(pbit);
    send_bit(stop1);
    for (int i = 1; i < nstop; i++) send_bit(1'b1);
    send_bit(1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(negedge clk);
    check("reset_rx_push",   {31'b0, rx_push},   32'd0);
    check("reset_rx_data",   {24'b0, rx_data},   32'd0);
    check("reset_rx_status", {29'b0, rx_status}, 32'd0);
    check("reset_overrun",   {31'b0, overrun},   32'd0);
    check("reset_rx_busy",   {31'b0, rx_busy},   32'd0);
    rst = 1'b0;
    wait_ticks(4);

    send_frame(2'b11, 0, 0, 0, 8'hA5, 0, 1, 1, 0);
    send_frame(2'b10, 1, 1, 0, 8'h41, 0, 1, 1, 0);
    send_frame(2'b10, 1, 1, 0, 8'h41, 1, 1, 1, 0);
    send_frame(2'b00, 1, 0, 0, 8'h1F, 0, 0, 2, 0);

    // Line held low for two 8N1 frame times: one break character only.
    word_len = 2'b11; par_en = 1'b0;
    exp_q.push_back(model(2'b11, 0, 0, 0, 8'h00, 0, 0, 0));
    sin = 1'b0;
    wait_ticks(2 * 10 * OS);
    check("brk_busy_while_low", {31'b0, rx_busy}, 32'd1);
    sin = 1'b1;
    wait_ticks(2 * OS);
    check("brk_idle_after_high", {31'b0, rx_busy}, 32'd0);
    send_frame(2'b11, 0, 0, 0, 8'h5A, 0, 1, 1, 0);

    sin = 1'b0;
    wait_ticks(4);
    check("glitch_busy", {31'b0, rx_busy}, 32'd1);
    sin = 1'b1;
    wait_ticks(2 * OS);
    check("glitch_idle", {31'b0, rx_busy}, 32'd0);

    send_frame(2'b11, 0, 0, 0, 8'h77, 0, 1, 1, 1);
    fifo_full = 1'b0;

    // Reset in the middle of the data bits abandons the frame.
    word_len = 2'b11; par_en = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    check("mid_frame_busy", {31'b0, rx_busy}, 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid_rx_data",   {24'b0, rx_data},   32'd0);
    check("rst_mid_rx_status", {29'b0, rx_status}, 32'd0);
    check("rst_mid_rx_busy",   {31'b0, rx_busy},   32'd0);
    check("rst_mid_overrun",   {31'b0, overrun},   32'd0);
    rst = 1'b0;
    sin = 1'b1;
    wait_ticks(12 * OS);
    send_frame(2'b11, 0, 0, 0, 8'h3C, 0, 1, 1, 0);

    for (int k = 0; k < 24; k++) begin
      logic [7:0] d;
      d = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom);
      send_frame(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), d,
                 ($urandom % 5) == 0, ($urandom % 6) != 0, 1 + int'($urandom % 2),
                 ($urandom % 6) == 0);
    end
    fifo_full = 1'b0;
    wait_ticks(2 * OS);
    check("pending_events", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
